// File: rtl/esm_core.sv
// Sequencing controller for the ESM instruction buffer: circular-queue pointers,
// occupancy tracking and a FILL/RUN/FLUSH issue gate with a prefill timeout.
module esm_core #(
  parameter int unsigned Instruction_word_size = 16,
  parameter int unsigned bs                    = 16,
  parameter int unsigned PREFILL               = 4,
  parameter int unsigned FILL_TIMEOUT          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [$clog2(bs)-1:0]    wr_index,
  output logic [$clog2(bs)-1:0]    rd_index,
  output logic [$clog2(bs):0]      count,
  output logic [1:0]               state_o
);

  localparam int unsigned AW   = $clog2(bs);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TW   = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
  localparam int unsigned TMAX = (FILL_TIMEOUT > 0) ? FILL_TIMEOUT - 1 : 0;

  if (bs < 2 || (bs & (bs - 1)) != 0 || PREFILL < 1 || PREFILL > bs ||
      Instruction_word_size < 1) begin : g_param_err
    $error("esm_core: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   fill_timer;
  logic [TW-1:0]   fill_timer_nxt;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;
  logic            timeout_hit;

  assign state_o = state;

  // Handshakes, occupancy update and next-state selection.
  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    wr_en          = 1'b0;
    count_nxt      = count;
    timeout_hit    = 1'b0;
    state_nxt      = state;
    fill_timer_nxt = '0;

    in_ready  = (count < CW'(bs)) && !flush && (state != S_FLUSH);
    out_valid = (state == S_RUN) && (count != '0) && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_en     = push;

    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    timeout_hit = (FILL_TIMEOUT != 0) && (fill_timer == TW'(TMAX)) &&
                  (count != '0) && !push;

    case (state)
      S_FILL: begin
        if ((count_nxt >= CW'(PREFILL)) || timeout_hit) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (count_nxt == '0) state_nxt = S_FILL;
      end
      S_FLUSH: state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase

    if (flush) state_nxt = S_FLUSH;

    // Timer only runs while parked in FILL holding entries with no new arrivals.
    if ((state == S_FILL) && (state_nxt == S_FILL) && !push && (count != '0)) begin
      fill_timer_nxt = (fill_timer == TW'(TMAX)) ? fill_timer : fill_timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // Pointers, occupancy and timer; flush discards everything at the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_index   <= '0;
      rd_index   <= '0;
      count      <= '0;
      fill_timer <= '0;
    end else begin
      if (push) wr_index <= wr_index + AW'(1);
      if (pop)  rd_index <= rd_index + AW'(1);
      count      <= count_nxt;
      fill_timer <= fill_timer_nxt;
    end
  end

endmodule
